mutex_lease_monitor: RTL and testbench

- Sits directly downstream of mutex and consumes its one-hot grant vector.
- Tracks the current owner and how long the lease has been held.
- Revokes a lease that exceeds MAX_HOLD cycles by pulsing revoke_o back into the mutex release path.
- Flags protocol errors: non-one-hot grant, release from a non-owner. Keeps saturating grant and timeout statistics for the bench and for debug.

---
 rtl/mutex_pkg.sv | 35 +++
 rtl/mutex_sat_counter.sv | 23 ++
 rtl/mutex_lease_monitor.sv | 162 ++++++++++++++++
 tb/tb_mutex_lease_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mutex_pkg.sv
// Shared types and helpers for the mutex and its lease monitor.
package mutex_pkg;

  localparam int N_REQ_DEF = 4;
  // Widest grant vector the helper functions accept.
  localparam int MAX_REQ   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REVOKE    = 2'd2,
    WAIT_DROP = 2'd3
  } lease_state_e;

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [MAX_REQ-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_REQ'(1))) == '0);
  endfunction

  // More than one bit set.
  function automatic logic is_multihot(input logic [MAX_REQ-1:0] vec);
    return (vec & (vec - MAX_REQ'(1))) != '0;
  endfunction

  // Index of the lowest set bit; 0 when the vector is zero.
  function automatic logic [4:0] onehot2idx(input logic [MAX_REQ-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mutex_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module mutex_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count up, stick at all-ones, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mutex_lease_monitor.sv
// Watches the mutex grant vector, times each lease, revokes overlong leases
// and records protocol errors and lease/timeout statistics.
//
// Handshake: grant_i is a level (one-hot or zero) owned by the mutex;
// release_i is a one-cycle strobe from the owner; revoke_o is a one-cycle
// strobe back to the mutex asking it to drop the owner's grant. No
// back-pressure exists on any of these signals.
module mutex_lease_monitor
  import mutex_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            grant_i,
  input  logic [N_REQ-1:0]            release_i,
  input  logic                        clr_i,
  output logic [N_REQ-1:0]            revoke_o,
  output logic                        owner_valid_o,
  output logic [$clog2(N_REQ)-1:0]    owner_id_o,
  output logic [$clog2(MAX_HOLD+1)-1:0] hold_cnt_o,
  output logic                        err_multi_o,
  output logic                        err_rel_o,
  output logic [CNT_W-1:0]            grant_cnt_o,
  output logic [CNT_W-1:0]            timeout_cnt_o
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int HW   = $clog2(MAX_HOLD + 1);

  lease_state_e        state;
  logic [MAX_REQ-1:0]  g_ext;
  logic [N_REQ-1:0]    own_mask;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_one;
  logic                grant_multi;
  logic                grant_own;
  logic                rel_own;
  logic                rel_other;
  logic                at_limit;
  logic                grant_inc;
  logic                timeout_inc;

  // Decode the grant/release vectors against the tracked owner.
  always_comb begin
    g_ext              = '0;
    g_ext[N_REQ-1:0]   = grant_i;
    grant_one          = is_onehot(g_ext);
    grant_multi        = is_multihot(g_ext);
    grant_idx          = ID_W'(onehot2idx(g_ext));
    own_mask           = N_REQ'(1) << owner_id_o;
    grant_own          = grant_i[owner_id_o];
    rel_own            = release_i[owner_id_o];
    rel_other          = |(release_i & ~own_mask);
    at_limit           = (hold_cnt_o == HW'(MAX_HOLD - 1));
    grant_inc          = 1'b0;
    timeout_inc        = 1'b0;
    case (state)
      IDLE:      grant_inc   = grant_one;
      HELD: begin
        grant_inc   = !grant_own && grant_one;
        timeout_inc = grant_own && !rel_own && at_limit;
      end
      WAIT_DROP: grant_inc   = !grant_own && grant_one;
      default:   grant_inc   = 1'b0;
    endcase
  end

  // Lease FSM: owner, hold counter and the revoke strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner_valid_o <= 1'b0;
      owner_id_o    <= '0;
      hold_cnt_o    <= '0;
      revoke_o      <= '0;
    end else begin
      revoke_o <= '0;
      case (state)
        IDLE: begin
          if (grant_one) begin
            state         <= HELD;
            owner_id_o    <= grant_idx;
            owner_valid_o <= 1'b1;
            hold_cnt_o    <= '0;
          end
        end
        HELD: begin
          if (!grant_own && grant_one) begin
            // Same-cycle handover to a different requester.
            owner_id_o <= grant_idx;
            hold_cnt_o <= '0;
          end else if (!grant_own || rel_own) begin
            state         <= IDLE;
            owner_valid_o <= 1'b0;
            hold_cnt_o    <= '0;
          end else if (at_limit) begin
            state      <= REVOKE;
            hold_cnt_o <= HW'(MAX_HOLD);
            revoke_o   <= own_mask;
          end else begin
            hold_cnt_o <= hold_cnt_o + HW'(1);
          end
        end
        REVOKE: begin
          state <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!grant_own) begin
            if (grant_one) begin
              state      <= HELD;
              owner_id_o <= grant_idx;
              hold_cnt_o <= '0;
            end else begin
              state         <= IDLE;
              owner_valid_o <= 1'b0;
              hold_cnt_o    <= '0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          owner_valid_o <= 1'b0;
          hold_cnt_o    <= '0;
        end
      endcase
    end
  end

  // Sticky protocol error flags; clear beats a coincident error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_multi_o <= 1'b0;
      err_rel_o   <= 1'b0;
    end else if (clr_i) begin
      err_multi_o <= 1'b0;
      err_rel_o   <= 1'b0;
    end else begin
      if (grant_multi)                err_multi_o <= 1'b1;
      if (owner_valid_o && rel_other) err_rel_o   <= 1'b1;
    end
  end

  mutex_sat_counter #(.W(CNT_W)) u_grant_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_inc),
    .clr   (clr_i),
    .q     (grant_cnt_o)
  );

  mutex_sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (timeout_inc),
    .clr   (clr_i),
    .q     (timeout_cnt_o)
  );

endmodule

// File: tb/tb_mutex_lease_monitor.sv
// Directed bench for mutex_lease_monitor (N_REQ=4, MAX_HOLD=8). A second
// instance with 2-bit counters shares the stimulus for the saturation case.
module tb_mutex_lease_monitor;
  import mutex_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [3:0] grant;
  logic [3:0] rel;
  logic       clr;

  logic [3:0]  revoke;
  logic        owner_valid;
  logic [1:0]  owner_id;
  logic [3:0]  hold_cnt;
  logic        err_multi;
  logic        err_rel;
  logic [15:0] grant_cnt;
  logic [15:0] timeout_cnt;

  logic [3:0]  s_revoke;
  logic        s_owner_valid;
  logic [1:0]  s_owner_id;
  logic [3:0]  s_hold_cnt;
  logic        s_err_multi;
  logic        s_err_rel;
  logic [1:0]  s_grant_cnt;
  logic [1:0]  s_timeout_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mutex_lease_monitor #(.N_REQ(4), .MAX_HOLD(8), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .grant_i       (grant),
    .release_i     (rel),
    .clr_i         (clr),
    .revoke_o      (revoke),
    .owner_valid_o (owner_valid),
    .owner_id_o    (owner_id),
    .hold_cnt_o    (hold_cnt),
    .err_multi_o   (err_multi),
    .err_rel_o     (err_rel),
    .grant_cnt_o   (grant_cnt),
    .timeout_cnt_o (timeout_cnt)
  );

  mutex_lease_monitor #(.N_REQ(4), .MAX_HOLD(8), .CNT_W(2)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .grant_i       (grant),
    .release_i     (rel),
    .clr_i         (clr),
    .revoke_o      (s_revoke),
    .owner_valid_o (s_owner_valid),
    .owner_id_o    (s_owner_id),
    .hold_cnt_o    (s_hold_cnt),
    .err_multi_o   (s_err_multi),
    .err_rel_o     (s_err_rel),
    .grant_cnt_o   (s_grant_cnt),
    .timeout_cnt_o (s_timeout_cnt)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_lease(input string tag, input int v, input int id, input int hc, input int rv);
    chk({tag, ".valid"},  32'(owner_valid), 32'(v));
    if (v != 0) chk({tag, ".id"}, 32'(owner_id), 32'(id));
    chk({tag, ".hold"},   32'(hold_cnt), 32'(hc));
    chk({tag, ".revoke"}, 32'(revoke), 32'(rv));
  endtask

  task automatic chk_stats(input string tag, input int em, input int er, input int gc, input int tc);
    chk({tag, ".err_multi"}, 32'(err_multi), 32'(em));
    chk({tag, ".err_rel"},   32'(err_rel), 32'(er));
    chk({tag, ".grant_cnt"}, 32'(grant_cnt), 32'(gc));
    chk({tag, ".tmo_cnt"},   32'(timeout_cnt), 32'(tc));
  endtask

  // ---------------- driver ----------------
  // Advance one clock and settle just after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] g, input logic [3:0] r, input logic c);
    grant = g;
    rel   = r;
    clr   = c;
  endtask

  // Safety net so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #10;
    chk_lease("reset", 0, 0, 0, 0);
    chk("reset.id", 32'(owner_id), 32'd0);
    chk_stats("reset", 0, 0, 0, 0);
    chk("reset.sat_gc", 32'(s_grant_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic lease: 0010 held 3 cycles then released.
    drive(4'b0010, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_lease("lease1", 1, 1, i, 0);
    end
    chk("lease1.gc", 32'(grant_cnt), 32'd1);
    drive(4'b0010, 4'b0010, 1'b0);
    cyc();
    chk_lease("lease1.rel", 0, 0, 0, 0);
    drive(4'b0000, 4'b0000, 1'b0);
    cyc();
    chk_lease("lease1.idle", 0, 0, 0, 0);
    chk_stats("lease1", 0, 0, 1, 0);

    // Timeout: 1000 held 12 cycles; revoke in cycle 9 with hold=8.
    drive(4'b1000, 4'b0000, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk_lease("tmo", 1, 3, (i <= 8) ? i - 1 : 8, (i == 9) ? 8 : 0);
      chk("tmo.tc", 32'(timeout_cnt), (i >= 9) ? 32'd1 : 32'd0);
    end
    drive(4'b0000, 4'b0000, 1'b0);
    cyc();
    chk_lease("tmo.drop", 0, 0, 0, 0);
    chk_stats("tmo", 0, 0, 2, 1);

    // Handover 0001 -> 0100 without an idle gap.
    drive(4'b0001, 4'b0000, 1'b0);
    cyc();
    chk_lease("ho.first", 1, 0, 0, 0);
    cyc();
    chk_lease("ho.first2", 1, 0, 1, 0);
    drive(4'b0100, 4'b0000, 1'b0);
    cyc();
    chk_lease("ho.second", 1, 2, 0, 0);
    chk_stats("ho", 0, 0, 4, 1);

    // Release from a non-owner while owner=2.
    drive(4'b0100, 4'b0001, 1'b0);
    cyc();
    chk_lease("erel", 1, 2, 1, 0);
    chk("erel.flag", 32'(err_rel), 32'd1);
    drive(4'b0000, 4'b0000, 1'b0);
    cyc();
    chk_lease("erel.idle", 0, 0, 0, 0);

    // Multi-hot grant in IDLE: sticky error, no lease.
    drive(4'b0110, 4'b0000, 1'b0);
    cyc();
    chk_lease("multi", 0, 0, 0, 0);
    chk_stats("multi", 1, 1, 4, 1);
    drive(4'b0000, 4'b0000, 1'b0);
    cyc();
    chk_stats("multi.sticky", 1, 1, 4, 1);

    // Release strobe in IDLE is ignored.
    drive(4'b0000, 4'b0010, 1'b1);
    cyc();
    chk_stats("clr", 0, 0, 0, 0);
    drive(4'b0000, 4'b0010, 1'b0);
    cyc();
    chk_stats("idle_rel", 0, 0, 0, 0);

    // Clear wins over a coincident lease start; FSM still takes the lease.
    drive(4'b0001, 4'b0000, 1'b1);
    cyc();
    chk_lease("clrwin", 1, 0, 0, 0);
    chk_stats("clrwin", 0, 0, 0, 0);
    drive(4'b0000, 4'b0000, 1'b0);
    cyc();
    chk_lease("clrwin.idle", 0, 0, 0, 0);

    // Release arriving when hold would step to 7, then exactly at 7.
    for (int n = 7; n <= 8; n++) begin
      drive(4'b0100, 4'b0000, 1'b0);
      for (int i = 0; i < n; i++) begin
        cyc();
        chk("coin.hold", 32'(hold_cnt), 32'(i));
      end
      drive(4'b0100, 4'b0100, 1'b0);
      cyc();
      chk_lease("coin.rel", 0, 0, 0, 0);
      drive(4'b0000, 4'b0000, 1'b0);
      cyc();
      chk_lease("coin.after", 0, 0, 0, 0);
      chk_stats("coin", 0, 0, n - 6, 0);
    end

    // Asynchronous reset in the middle of a lease with an error pending.
    drive(4'b0010, 4'b0000, 1'b0);
    cyc();
    drive(4'b0010, 4'b0001, 1'b0);
    cyc();
    chk_lease("mid", 1, 1, 1, 0);
    chk_stats("mid", 0, 1, 3, 0);
    rst_n = 1'b0;
    #1;
    chk_lease("midrst", 0, 0, 0, 0);
    chk("midrst.id", 32'(owner_id), 32'd0);
    chk_stats("midrst", 0, 0, 0, 0);
    drive(4'b0000, 4'b0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Five back-to-back leases via handover; 2-bit counter saturates at 3.
    begin
      logic [3:0] seq [5];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
      seq[3] = 4'b1000; seq[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin
        drive(seq[i], 4'b0000, 1'b0);
        cyc();
        chk("sat.gc16", 32'(grant_cnt), 32'(i + 1));
        chk("sat.gc2", 32'(s_grant_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        chk("sat.hold", 32'(hold_cnt), 32'd0);
      end
    end
    drive(4'b0000, 4'b0000, 1'b0);
    cyc();
    chk("sat.final", 32'(s_grant_cnt), 32'd3);
    chk_lease("sat.idle", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
